// File: rtl/instr_cache_miss_ctrl_pkg.sv
// Shared types for the instruction-cache miss path: physical address,
// cache-line payload and the miss-controller state encoding.
package instr_cache_miss_ctrl_pkg;

  localparam int unsigned PADDR_W           = 32;
  localparam int unsigned ICACHE_LINE_BYTES = 16;
  localparam int unsigned ICACHE_LINE_W     = ICACHE_LINE_BYTES * 8;

  typedef logic [PADDR_W-1:0]       paddr_t;
  typedef logic [ICACHE_LINE_W-1:0] icache_data_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    FILL = 2'd3
  } icache_ctrl_state_t;

endpackage

// File: rtl/instr_cache_line_buf.sv
// Line buffer that assembles memory response beats into a full cache line,
// beat 0 in the least significant bits.
module instr_cache_line_buf #(
  parameter int unsigned NUM_BEATS  = 4,
  parameter int unsigned BEAT_WIDTH = 32,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_we,
  input  logic                            i_clr,
  input  logic [IDX_W-1:0]                i_beat_idx,
  input  logic [BEAT_WIDTH-1:0]           i_beat_data,
  output logic [NUM_BEATS*BEAT_WIDTH-1:0] o_line
);

  localparam int unsigned LINE_W = NUM_BEATS * BEAT_WIDTH;

  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_d;

  // Clear wins over write so a new miss always starts from an empty line.
  always_comb begin
    line_d = line_q;
    if (i_clr) begin
      line_d = '0;
    end else if (i_we) begin
      for (int b = 0; b < NUM_BEATS; b++) begin
        if (i_beat_idx == IDX_W'(b)) begin
          line_d[b*BEAT_WIDTH +: BEAT_WIDTH] = i_beat_data;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign o_line = line_q;

endmodule

// File: rtl/instr_cache_miss_ctrl.sv
// Instruction-cache miss controller: issues one line-aligned memory read per
// miss, assembles the response beats and strobes the line into the cache.
module instr_cache_miss_ctrl
  import instr_cache_miss_ctrl_pkg::*;
#(
  parameter int unsigned CACHELINE_SIZE      = 16,
  parameter int unsigned CACHELINE_SIZE_BITS = 4,
  parameter int unsigned BEAT_WIDTH          = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_miss,
  input  logic [PADDR_W-1:0]            i_miss_paddr,
  output logic                          o_miss_busy,
  output logic                          o_miss_done,
  input  logic                          i_flush,
  output logic                          o_mem_req,
  output logic [PADDR_W-1:0]            o_mem_paddr,
  input  logic                          i_mem_ack,
  input  logic                          i_mem_resp_valid,
  input  logic [BEAT_WIDTH-1:0]         i_mem_resp_data,
  output logic                          o_fill,
  output logic [PADDR_W-1:0]            o_fill_paddr,
  output logic [CACHELINE_SIZE*8-1:0]   o_fill_data,
  input  logic [31:0]                   i_log_fd
);

  localparam int unsigned LINE_W    = CACHELINE_SIZE * 8;
  localparam int unsigned NUM_BEATS = LINE_W / BEAT_WIDTH;
  localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);
  localparam paddr_t OFFSET_MASK =
    paddr_t'((64'd1 << CACHELINE_SIZE_BITS) - 64'd1);

  icache_ctrl_state_t state_q, state_d;
  paddr_t             addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               discard_q, discard_d;
  logic               buf_we;
  logic               buf_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
    end
  end

  // A flushed transaction still drains every beat so the memory side stays in
  // step; only the final fill strobe is dropped.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;
    buf_we    = 1'b0;
    buf_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_miss && !i_flush) begin
          addr_d  = i_miss_paddr & ~OFFSET_MASK;
          cnt_d   = '0;
          buf_clr = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_flush) discard_d = 1'b1;
        if (i_mem_ack) begin
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (i_flush) discard_d = 1'b1;
        if (i_mem_resp_valid) begin
          buf_we = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = FILL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FILL: begin
        discard_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  instr_cache_line_buf #(
    .NUM_BEATS  (NUM_BEATS),
    .BEAT_WIDTH (BEAT_WIDTH),
    .IDX_W      (CNT_W)
  ) u_line_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_we        (buf_we),
    .i_clr       (buf_clr),
    .i_beat_idx  (cnt_q),
    .i_beat_data (i_mem_resp_data),
    .o_line      (o_fill_data)
  );

  assign o_miss_busy  = (state_q != IDLE);
  assign o_mem_req    = (state_q == REQ);
  assign o_mem_paddr  = addr_q;
  assign o_fill_paddr = addr_q;
  assign o_fill       = (state_q == FILL) && !discard_q && !i_flush;
  assign o_miss_done  = o_fill;

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (o_fill && (i_log_fd != 32'd0)) begin
      $display("icache fill paddr=%h data=%h", o_fill_paddr, o_fill_data);
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache_miss_ctrl.sv
// Directed bench for instr_cache_miss_ctrl: stimulus pushes expected memory
// requests and fills; a negedge monitor pops and compares them.
module tb_instr_cache_miss_ctrl;

  logic         clk;
  logic         rst_n;
  logic         i_miss;
  logic [31:0]  i_miss_paddr;
  logic         o_miss_busy;
  logic         o_miss_done;
  logic         i_flush;
  logic         o_mem_req;
  logic [31:0]  o_mem_paddr;
  logic         i_mem_ack;
  logic         i_mem_resp_valid;
  logic [31:0]  i_mem_resp_data;
  logic         o_fill;
  logic [31:0]  o_fill_paddr;
  logic [127:0] o_fill_data;
  logic [31:0]  i_log_fd;

  typedef struct {
    logic [31:0]  paddr;
    logic [127:0] data;
    int           cyc;
  } fill_exp_t;

  fill_exp_t   fill_q[$];
  logic [31:0] req_q[$];
  int          n_tests;
  int          n_fail;
  int          cyc;

  instr_cache_miss_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_miss           (i_miss),
    .i_miss_paddr     (i_miss_paddr),
    .o_miss_busy      (o_miss_busy),
    .o_miss_done      (o_miss_done),
    .i_flush          (i_flush),
    .o_mem_req        (o_mem_req),
    .o_mem_paddr      (o_mem_paddr),
    .i_mem_ack        (i_mem_ack),
    .i_mem_resp_valid (i_mem_resp_valid),
    .i_mem_resp_data  (i_mem_resp_data),
    .o_fill           (o_fill),
    .o_fill_paddr     (o_fill_paddr),
    .o_fill_data      (o_fill_data),
    .i_log_fd         (i_log_fd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted request and every fill must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_mem_req && i_mem_ack) begin
        if (req_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_mem_req: got paddr 0x%0h expected none", o_mem_paddr);
        end else begin
          check("mem_paddr", o_mem_paddr, req_q.pop_front());
        end
      end
      if (o_fill || o_miss_done) begin
        check("done_with_fill", o_miss_done, o_fill);
        if (fill_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_fill: got paddr 0x%0h expected no fill", o_fill_paddr);
        end else begin
          fill_exp_t e;
          e = fill_q.pop_front();
          check("fill_paddr", o_fill_paddr, e.paddr);
          check("fill_data", o_fill_data, e.data);
          check("fill_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_miss(input logic [31:0] a, input logic [31:0] exp_a);
    req_q.push_back(exp_a);
    i_miss       = 1'b1;
    i_miss_paddr = a;
    tick();
    i_miss       = 1'b0;
    i_miss_paddr = '0;
  endtask

  task automatic do_ack();
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
  endtask

  task automatic send_beats(input logic [127:0] line, input int gap, input logic flush_after2);
    for (int b = 0; b < 4; b++) begin
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = line[b*32 +: 32];
      tick();
      i_mem_resp_valid = 1'b0;
      i_mem_resp_data  = 32'hDEAD_BEEF;
      if (b == 1 && flush_after2) begin
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
      end
      if (b < 3) repeat (gap) tick();
    end
  endtask

  task automatic expect_fill(input logic [31:0] a, input logic [127:0] line);
    fill_exp_t e;
    e.paddr = a;
    e.data  = line;
    e.cyc   = cyc;
    fill_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_miss_busy, 0);
    check({tag, "_mem_req"}, o_mem_req, 0);
    check({tag, "_fill"}, o_fill, 0);
    check({tag, "_done"}, o_miss_done, 0);
    check({tag, "_mem_paddr"}, o_mem_paddr, 0);
    check({tag, "_fill_paddr"}, o_fill_paddr, 0);
    check({tag, "_fill_data"}, o_fill_data, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] line;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n            = 1'b0;
    i_miss           = 1'b0;
    i_miss_paddr     = '0;
    i_flush          = 1'b0;
    i_mem_ack        = 1'b0;
    i_mem_resp_valid = 1'b0;
    i_mem_resp_data  = '0;
    i_log_fd         = '0;
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic miss: ack one cycle later, back-to-back beats.
    line = 128'h44444444_33333333_22222222_11111111;
    issue_miss(32'h0000_1234, 32'h0000_1230);
    check("a_busy", o_miss_busy, 1);
    check("a_mem_req", o_mem_req, 1);
    check("a_req_paddr", o_mem_paddr, 32'h0000_1230);
    do_ack();
    send_beats(line, 0, 1'b0);
    expect_fill(32'h0000_1230, line);
    tick();
    check("a_busy_after", o_miss_busy, 0);

    // Stalled ack: request held stable; miss and stray beats ignored.
    line = 128'hA5A5A5A5_0F0F0F0F_CAFEF00D_01234567;
    issue_miss(32'h0000_2468, 32'h0000_2460);
    for (int s = 0; s < 5; s++) begin
      i_miss           = 1'b1;
      i_miss_paddr     = 32'h0000_2000;
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = 32'hBAD0_BAD0;
      check("b_stall_req", o_mem_req, 1);
      check("b_stall_paddr", o_mem_paddr, 32'h0000_2460);
      tick();
    end
    i_miss           = 1'b0;
    i_miss_paddr     = '0;
    i_mem_resp_valid = 1'b0;
    do_ack();
    send_beats(line, 0, 1'b0);
    expect_fill(32'h0000_2460, line);
    tick();
    check("b_busy_after", o_miss_busy, 0);

    // Two-cycle gaps between beats.
    line = 128'h89ABCDEF_76543210_FEDCBA98_13579BDF;
    issue_miss(32'h0000_ABCF, 32'h0000_ABC0);
    do_ack();
    send_beats(line, 2, 1'b0);
    expect_fill(32'h0000_ABC0, line);
    tick();
    check("c_busy_after", o_miss_busy, 0);

    // Flush after second beat: beats drain, no fill.
    line = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    issue_miss(32'h0000_5558, 32'h0000_5550);
    do_ack();
    send_beats(line, 0, 1'b1);
    check("d_no_fill", o_fill, 0);
    check("d_no_done", o_miss_done, 0);
    tick();
    check("d_busy_after", o_miss_busy, 0);

    // Miss together with flush in IDLE is dropped.
    i_miss       = 1'b1;
    i_miss_paddr = 32'h0000_6660;
    i_flush      = 1'b1;
    tick();
    i_miss  = 1'b0;
    i_flush = 1'b0;
    check("e_no_req", o_mem_req, 0);
    check("e_not_busy", o_miss_busy, 0);
    tick();

    // Flush during the FILL cycle suppresses that cycle's strobe.
    line = 128'h00000004_00000003_00000002_00000001;
    issue_miss(32'h0000_8880, 32'h0000_8880);
    do_ack();
    send_beats(line, 0, 1'b0);
    i_flush = 1'b1;
    #1;
    check("f_fill_flushed", o_fill, 0);
    check("f_done_flushed", o_miss_done, 0);
    tick();
    i_flush = 1'b0;
    check("f_busy_after", o_miss_busy, 0);

    // Reset in RECV drops the transaction.
    issue_miss(32'h0000_7774, 32'h0000_7770);
    do_ack();
    for (int b = 0; b < 2; b++) begin
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = 32'h1000_0000 + 32'(b);
      tick();
    end
    i_mem_resp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("g_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    for (int b = 0; b < 3; b++) begin
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = 32'h2000_0000 + 32'(b);
      tick();
    end
    i_mem_resp_valid = 1'b0;
    repeat (3) tick();
    check("g_busy_after", o_miss_busy, 0);
    check("g_fill_data_clear", o_fill_data, 0);

    repeat (3) tick();
    check("fill_queue_drained", 128'(fill_q.size()), 0);
    check("req_queue_drained", 128'(req_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
